// File: rtl/pipe_reg_nstage.sv
// pipe_reg_nstage: elastic pipeline register, DEPTH stages of N-bit data.
// Each stage carries a valid bit; a combinational ready chain lets empty
// stages collapse bubbles while the output is stalled. Synchronous flush
// clears every valid bit, and a registered occupancy count is provided.

// One pipeline stage: a valid flop and a data flop with load/flush control.
module pipe_reg_nstage_stage #(
  parameter int           N         = 16,
  parameter logic [N-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         ld,       // this stage may take the word offered to it
  input  logic         vin,      // valid of the word offered
  input  logic [N-1:0] din,      // data of the word offered
  output logic         vld_q,
  output logic         vld_d,    // next-state valid, used for the count
  output logic [N-1:0] data_q
);
  logic [N-1:0] data_d;

  // Next state: flush clears valid only; a load copies valid, and data only
  // when the incoming word is real, so a bubble never overwrites held data.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (flush) begin
      vld_d = 1'b0;
    end else if (ld) begin
      vld_d = vin;
      if (vin) data_d = din;
    end
  end

  // Stage flops, asynchronously cleared to empty / RESET_VAL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= RESET_VAL;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end
endmodule

// Top level: ready chain, stage array, occupancy counter.
module pipe_reg_nstage #(
  parameter int           N         = 16,
  parameter int           DEPTH     = 4,
  parameter logic [N-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0]               in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N-1:0]               out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0]        vld_pipe;   // current stage valids, 0 = input side
  logic [DEPTH-1:0]        vld_nxt;    // valids after the coming edge
  logic [DEPTH-1:0]        rdy;        // stage i may load this cycle
  logic [DEPTH-1:0]        vin;        // valid offered to stage i
  logic [DEPTH-1:0][N-1:0] din;        // data offered to stage i
  logic [DEPTH-1:0][N-1:0] data_pipe;  // current stage data
  logic [CW-1:0]           count_d, count_q;

  // Ready chain from the output backwards: a stage can load if it is empty
  // or its successor can load. A running variable keeps the chain acyclic.
  always_comb begin
    logic r;
    r   = out_ready;
    rdy = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      r      = ~vld_pipe[i] | r;
      rdy[i] = r;
    end
  end

  // Word offered to each stage: the input port for stage 0, else predecessor.
  always_comb begin
    vin    = '0;
    din    = '0;
    vin[0] = in_valid;
    din[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      vin[i] = vld_pipe[i-1];
      din[i] = data_pipe[i-1];
    end
  end

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_stage
      pipe_reg_nstage_stage #(
        .N         (N),
        .RESET_VAL (RESET_VAL)
      ) u_stage (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .ld     (rdy[g]),
        .vin    (vin[g]),
        .din    (din[g]),
        .vld_q  (vld_pipe[g]),
        .vld_d  (vld_nxt[g]),
        .data_q (data_pipe[g])
      );
    end
  endgenerate

  // Occupancy after the coming edge: popcount of the next-state valids.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) count_d = count_d + CW'(vld_nxt[i]);
  end

  // Registered occupancy so count never depends combinationally on inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = vld_pipe[DEPTH-1];
  assign out_data  = data_pipe[DEPTH-1];
  assign count     = count_q;
endmodule

// File: tb/tb_pipe_reg_nstage.sv
// Bench for pipe_reg_nstage (N=16, DEPTH=4). The reference model is a FIFO
// queue of words inside the pipe: accept pushes, delivery pops and is
// compared, flush empties it. A negedge monitor applies the model; the main
// process drives directed scenarios, then random traffic.
module tb_pipe_reg_nstage;
  localparam int N     = 16;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] out_data;
  logic [2:0]   count;

  int checks = 0;
  int errors = 0;
  int delivered = 0;
  logic [N-1:0] model_q[$];

  pipe_reg_nstage #(.N(N), .DEPTH(DEPTH), .RESET_VAL(16'h0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: evaluates the transfer that the next rising edge
  // will perform, using values that are stable mid-cycle.
  always @(negedge clk) begin
    logic [N-1:0] exp_w;
    logic         exp_rdy;
    if (rst) begin
      model_q.delete();
    end else begin
      chk("count_vs_model", {29'd0, count}, model_q.size());
      exp_rdy = !flush && (model_q.size() < DEPTH || out_ready);
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      if (out_valid && model_q.size() == 0)
        chk("out_valid_when_empty", {31'd0, out_valid}, 32'd0);
      if (out_valid && out_ready) begin
        delivered++;
        if (model_q.size() == 0) begin
          chk("deliver_nothing_expected", {31'd0, out_valid}, 32'd0);
        end else begin
          exp_w = model_q.pop_front();
          chk("out_data", {16'd0, out_data}, {16'd0, exp_w});
        end
      end
      if (flush) model_q.delete();
      else if (in_valid && in_ready) model_q.push_back(in_data);
    end
  end

  task automatic drain();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (count == 0 && !out_valid) break;
      step();
    end
    chk("drain_count", {29'd0, count}, 32'd0);
  endtask

  // Push one word into an empty pipe with out_ready=1 and check it appears
  // exactly DEPTH-1 edges after the accepting edge.
  task automatic lat_check(input logic [N-1:0] d);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    step();
    in_valid = 1'b0;
    chk("lat_edge0", {31'd0, out_valid}, 32'd0);
    for (int j = 1; j < DEPTH - 1; j++) begin
      step();
      chk("lat_early", {31'd0, out_valid}, 32'd0);
    end
    step();
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_data", {16'd0, out_data}, {16'd0, d});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nacc;
    int d0;
    logic acc;
    logic [N-1:0] dv;

    // Reset state
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    @(posedge clk); #3 rst = 1'b0;
    #1 chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    step();

    // Streaming 1..8 with out_ready held high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = 16'(i);
      step();
      if (i <= DEPTH - 1) chk("stream_lat_early", {31'd0, out_valid}, 32'd0);
      if (i == DEPTH) begin
        chk("stream_first_valid", {31'd0, out_valid}, 32'd1);
        chk("stream_first_data", {16'd0, out_data}, 32'd1);
      end
      if (i >= DEPTH) chk("stream_count", {29'd0, count}, DEPTH);
    end
    drain();

    // Backpressure fill
    out_ready = 1'b0;
    in_valid  = 1'b1;
    nacc = 0;
    dv   = 16'h00A0;
    for (int i = 0; i < 8; i++) begin
      in_data = dv;
      #1 acc = in_ready;
      step();
      if (acc) begin
        nacc++;
        dv = dv + 16'd1;
      end
    end
    chk("bp_accepted", nacc, DEPTH);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_count", {29'd0, count}, DEPTH);
    d0 = delivered;
    drain();
    chk("bp_delivered", delivered - d0, DEPTH);

    // Bubble collapse
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0011; step();
    in_valid = 1'b0; step(); step();
    in_valid = 1'b1; in_data = 16'h0022; step();
    in_valid = 1'b0; step(); step(); step();
    chk("bub_count", {29'd0, count}, 32'd2);
    chk("bub_head", {16'd0, out_data}, 32'h11);
    out_ready = 1'b1;
    step();
    chk("bub_b2b_valid", {31'd0, out_valid}, 32'd1);
    chk("bub_b2b_data", {16'd0, out_data}, 32'h22);
    step();
    chk("bub_empty", {31'd0, out_valid}, 32'd0);
    drain();

    // Full pass-through
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 10 && count != DEPTH; i++) begin
      in_data = 16'h0040 + 16'(i);
      step();
    end
    chk("pt_full", {29'd0, count}, DEPTH);
    in_data   = 16'h0055;
    out_ready = 1'b1;
    #1 chk("pt_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("pt_count", {29'd0, count}, DEPTH);
    drain();

    // Flush mid-stream
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 16'h0030 + 16'(i);
      step();
    end
    in_data = 16'h00FF;
    flush   = 1'b1;
    #1 chk("fl_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_count", {29'd0, count}, 32'd0);
    chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
    lat_check(16'h0077);
    drain();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 29) == 0);
      step();
    end
    drain();

    // Mid-cycle asynchronous reset with a full pipe
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 16'h0B00 + 16'(i);
      step();
    end
    in_valid = 1'b0;
    chk("ar_full", {29'd0, count}, DEPTH);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("ar_out_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_count", {29'd0, count}, 32'd0);
    chk("ar_out_data", {16'd0, out_data}, 32'd0);
    @(posedge clk); #3 rst = 1'b0;
    #1 chk("ar_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
